// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite read and write initiators:
// one-hot FSM encodings and AXI response codes.
package axi4_lite_pkg;

    localparam logic [3:0] IDLE      = 4'b0001;
    localparam logic [3:0] ADDR_DATA = 4'b0010;
    localparam logic [3:0] WT_RESP   = 4'b0100;
    localparam logic [3:0] ACK       = 4'b1000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_wr.sv
// AXI4-Lite single-beat write initiator: latches one user request, issues AW and W
// independently, waits for B and returns a one-cycle completion pulse with BRESP.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for wr_valid; request fields latched on accept
// ADDR_DATA | AW and W offered until each has handshaked (any order)
// WT_RESP   | bready high, waiting for bvalid
// ACK       | wr_ready pulse with the latched BRESP, then back to IDLE
module axi4_lite_wr
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [1:0]        wr_resp,
    output logic              busy,
    output logic [ADDR_W-1:0] s_axi_awaddr,
    output logic              s_axi_awvalid,
    input  logic              s_axi_awready,
    output logic [DATA_W-1:0] s_axi_wdata,
    output logic [STRB_W-1:0] s_axi_wstrb,
    output logic              s_axi_wvalid,
    input  logic              s_axi_wready,
    input  logic [1:0]        s_axi_bresp,
    input  logic              s_axi_bvalid,
    output logic              s_axi_bready
);

    logic [3:0]        state;
    logic              aw_done;
    logic              w_done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [STRB_W-1:0] strb_q;
    logic [1:0]        resp_q;

    logic aw_hs;
    logic w_hs;
    logic aw_next;
    logic w_next;

    // Outputs decode only registered state and flags, so no ready ever reaches a valid.
    assign s_axi_awvalid = (state == ADDR_DATA) && !aw_done;
    assign s_axi_wvalid  = (state == ADDR_DATA) && !w_done;
    assign s_axi_bready  = (state == WT_RESP);
    assign wr_ready      = (state == ACK);
    assign busy          = (state != IDLE);

    assign s_axi_awaddr  = s_axi_awvalid ? addr_q : '0;
    assign s_axi_wdata   = s_axi_wvalid  ? data_q : '0;
    assign s_axi_wstrb   = s_axi_wvalid  ? strb_q : '0;
    assign wr_resp       = wr_ready      ? resp_q : 2'b00;

    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid  && s_axi_wready;
    assign aw_next = aw_done || aw_hs;
    assign w_next  = w_done  || w_hs;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_valid) begin
                        addr_q  <= wr_addr;
                        data_q  <= wr_data;
                        strb_q  <= wr_strb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    aw_done <= aw_next;
                    w_done  <= w_next;
                    if (aw_next && w_next) begin
                        state <= WT_RESP;
                    end
                end
                WT_RESP: begin
                    if (s_axi_bvalid) begin
                        resp_q <= s_axi_bresp;
                        state  <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi4_lite_wr.md
Name: axi4_lite_wr

Overview:
User-side AXI4-Lite write initiator, the write-direction companion of the team's AXI4-Lite read initiator. It accepts one single-beat write request from user logic and latches address, data and strobe. It then issues the AW and W channels independently, waits for the B response, and returns a one-cycle completion pulse carrying BRESP. It sits between control/register-programming logic and an AXI4-Lite slave port, for example an IP configuration interface.

Parameters:
ADDR_W, 32, address width of wr_addr and s_axi_awaddr
DATA_W, 32, data width of wr_data and s_axi_wdata; must be 32 or 64
STRB_W, DATA_W/8, byte-strobe width (derived; not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
arst  input  1  asynchronous reset, active-high
wr_addr  input  ADDR_W  user write address, sampled when the request is accepted
wr_data  input  DATA_W  user write data, sampled when the request is accepted
wr_strb  input  STRB_W  user byte enables, sampled when the request is accepted
wr_valid  input  1  user request; held high until wr_ready
wr_ready  output  1  one-cycle completion pulse
wr_resp  output  2  BRESP of the completed write; valid only while wr_ready=1, else 0
busy  output  1  high whenever state is not IDLE
s_axi_awaddr  output  ADDR_W  latched address while awvalid=1, else 0
s_axi_awvalid  output  1  AW valid
s_axi_awready  input  1  AW ready
s_axi_wdata  output  DATA_W  latched data while wvalid=1, else 0
s_axi_wstrb  output  STRB_W  latched strobe while wvalid=1, else 0
s_axi_wvalid  output  1  W valid
s_axi_wready  input  1  W ready
s_axi_bresp  input  2  write response
s_axi_bvalid  input  1  B valid
s_axi_bready  output  1  B ready

Behaviour:
- Reset (async, arst=1): state=IDLE, aw_done=w_done=0, all latches 0. Every output is 0.
- The state machine is one-hot with four states: IDLE, ADDR_DATA, WT_RESP, ACK.
- IDLE:
  - When wr_valid=1, latch wr_addr, wr_data and wr_strb, clear aw_done and w_done, and go to ADDR_DATA.
  - Otherwise stay in IDLE.
- ADDR_DATA:
  - s_axi_awvalid = !aw_done; s_axi_wvalid = !w_done. Both are driven from state and flags only, never combinationally from any ready.
  - A valid, once high, stays high until its handshake completes.
  - An AW handshake (awvalid and awready) sets aw_done. A W handshake sets w_done.
  - Both handshakes may occur in the same cycle, in either order, or W before AW.
  - Go to WT_RESP on the edge where both flags are, or become, set, including a simultaneous final handshake.
- WT_RESP:
  - s_axi_bready=1.
  - When bvalid=1, latch bresp and go to ACK.
  - A bvalid arriving before both AW and W handshakes finish is not accepted, because bready=0 outside WT_RESP.
- ACK:
  - wr_ready=1 and wr_resp=latched bresp for exactly one cycle, then return to IDLE unconditionally.
- wr_valid is ignored outside IDLE.
- The user must deassert wr_valid in the wr_ready cycle. If wr_valid is still high in IDLE, a new transaction starts with the inputs present then.
- Latency: with awready=wready=1 and bvalid returned immediately, wr_valid sampled at edge N gives AW/W valid in cycle N+1, bready in N+2 and wr_ready in N+3. Back-to-back throughput is one write per 4 cycles minimum.
- BRESP is passed through unmodified: SLVERR and DECERR are reported, never retried.
- Reset mid-transaction returns to IDLE at once, with outputs 0. Protocol recovery of the slave is the system's responsibility.
- Illegal or unknown state encodings go to IDLE on the next edge.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - one-hot state localparams (IDLE=4'b0001, ADDR_DATA=4'b0010, WT_RESP=4'b0100, ACK=4'b1000);
  - response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- The package is shared with the read initiator.
- No sub-module: one flat module containing the FSM, the two handshake flags and the request/response latches.

Test Plan:
- Reset held, then released with all inputs 0 -> every output 0, busy=0.
- Write addr=0x0000_0010, data=0xDEAD_BEEF, strb=4'hF; awready=wready=1; bvalid with bresp=00 returned at once -> awaddr/wdata observed with both valids in the same cycle, wr_ready one cycle at N+3, wr_resp=00.
- awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 6 cycles with awaddr stable, then one bready cycle, then wr_ready.
- wready delayed 3 cycles, AW immediate, slave returns bresp=2'b10 -> wr_resp=2'b10 on the wr_ready cycle, 0 otherwise.
- Slave asserts bvalid early, during ADDR_DATA -> bready stays 0 until both handshakes finish, and the response is consumed only in WT_RESP.
- arst pulsed while in WT_RESP -> outputs 0 immediately. The next request, addr=0x24, data=0x1234_5678, strb=4'h3, completes normally with wstrb=4'h3.
